// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state encoding and BCD helper for the value selector
package bcd_pkg;

   // Decimal place weights for cursor positions 0..7
   localparam logic [31:0] POW10 [8] = '{
      32'd1, 32'd10, 32'd100, 32'd1000,
      32'd10000, 32'd100000, 32'd1000000, 32'd10000000
   };

   typedef enum logic {
      EDIT   = 1'b0,
      LOCKED = 1'b1
   } sel_state_t;

   // Elaboration-time BCD of a constant, used for the reset image of the digits
   function automatic logic [31:0] to_bcd_const(input int value, input int digits);
      logic [31:0] r;
      int          v;
      r = '0;
      v = value;
      for (int i = 0; i < 8; i++) begin
         if (i < digits) r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative shift-add-3 binary to BCD converter
module bin2bcd_seq #(
   parameter int                DIGITS    = 4,
   parameter int                BIN_W     = 14,
   parameter logic [4*DIGITS-1:0] RESET_BCD = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   logic [BIN_W-1:0]    shift_q;
   logic [4*DIGITS-1:0] acc_q;
   logic [4*DIGITS-1:0] acc_adj;
   logic [4*DIGITS-1:0] acc_next;
   logic [CNT_W-1:0]    cnt_q;
   logic                run_q;

   // One double-dabble step: correct every digit >= 5, then shift in the next bit
   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
      acc_next = {acc_adj[4*DIGITS-2:0], shift_q[BIN_W-1]};
   end

   // start (re)loads the operand; BIN_W steps later the result is published with done
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         bcd     <= RESET_BCD;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            shift_q <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b1;
         end else if (run_q) begin
            if (cnt_q == CNT_W'(BIN_W)) begin
               bcd   <= acc_q;
               done  <= 1'b1;
               run_q <= 1'b0;
            end else begin
               acc_q   <= acc_next;
               shift_q <= {shift_q[BIN_W-2:0], 1'b0};
               cnt_q   <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/bcd_value_select.sv
// rtl/bcd_value_select.sv - cursor-edited binary value with lock handshake and BCD readout
module bcd_value_select
   import bcd_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int BIN_W     = 14,
   parameter int MIN_VALUE = 0,
   parameter int MAX_VALUE = 9999,
   parameter int WRAP      = 1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        inc,
   input  logic                                        dec,
   input  logic                                        left,
   input  logic                                        right,
   input  logic                                        sel,
   input  logic                                        unlock,
   input  logic                                        load,
   input  logic [BIN_W-1:0]                            load_bin,
   output logic [BIN_W-1:0]                            value_bin,
   output logic [4*DIGITS-1:0]                         digits,
   output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] cursor,
   output logic                                        locked,
   output logic                                        busy,
   output logic                                        commit,
   output logic                                        ovf
);

   localparam int          CUR_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int          RANGE       = MAX_VALUE - MIN_VALUE + 1;
   localparam logic [31:0] RESET_BCD32 = to_bcd_const(MIN_VALUE, DIGITS);

   sel_state_t       state_q;
   logic             busy_q;
   logic             conv_done;
   logic             start;
   logic [BIN_W-1:0] next_value;

   logic acc_load, acc_sel, acc_unlock, acc_inc, acc_dec, acc_left, acc_right;
   logic load_ovf;
   int   step, vin, sum, diff, lb;
   int   inc_val, dec_val, load_val;

   // busy drops in the same cycle the converter publishes its result
   assign busy = busy_q & ~conv_done;

   // Arithmetic for each candidate action, with wrap/saturate and load clamping
   always_comb begin
      step = int'(POW10[cursor]);
      vin  = int'(value_bin);
      sum  = vin + step;
      diff = vin - step;
      lb   = int'(load_bin);

      inc_val = sum;
      if (sum > MAX_VALUE) inc_val = (WRAP != 0) ? (sum - RANGE) : MAX_VALUE;

      dec_val = diff;
      if (diff < MIN_VALUE) dec_val = (WRAP != 0) ? (diff + RANGE) : MIN_VALUE;

      load_val = lb;
      load_ovf = 1'b0;
      if (lb > MAX_VALUE) begin
         load_val = MAX_VALUE;
         load_ovf = 1'b1;
      end else if (lb < MIN_VALUE) begin
         load_val = MIN_VALUE;
         load_ovf = 1'b1;
      end
   end

   // Pick the single highest-priority action that is acceptable this cycle
   always_comb begin
      acc_load   = 1'b0;
      acc_sel    = 1'b0;
      acc_unlock = 1'b0;
      acc_inc    = 1'b0;
      acc_dec    = 1'b0;
      acc_left   = 1'b0;
      acc_right  = 1'b0;
      if (load)                                   acc_load   = 1'b1;
      else if (sel && state_q == EDIT)            acc_sel    = 1'b1;
      else if (unlock && state_q == LOCKED)       acc_unlock = 1'b1;
      else if (inc && state_q == EDIT && !busy)   acc_inc    = 1'b1;
      else if (dec && state_q == EDIT && !busy)   acc_dec    = 1'b1;
      else if (left && state_q == EDIT)           acc_left   = 1'b1;
      else if (right && state_q == EDIT)          acc_right  = 1'b1;

      start = acc_load | acc_inc | acc_dec;

      next_value = value_bin;
      if (acc_load)     next_value = BIN_W'(load_val);
      else if (acc_inc) next_value = BIN_W'(inc_val);
      else if (acc_dec) next_value = BIN_W'(dec_val);
   end

   // Edit/lock state machine with registered value, cursor and flag outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= EDIT;
         value_bin <= BIN_W'(MIN_VALUE);
         cursor    <= '0;
         locked    <= 1'b0;
         commit    <= 1'b0;
         ovf       <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         commit <= 1'b0;
         if (start)          busy_q <= 1'b1;
         else if (conv_done) busy_q <= 1'b0;

         value_bin <= next_value;

         if (acc_load) begin
            ovf     <= load_ovf;
            state_q <= LOCKED;
            locked  <= 1'b1;
         end else if (acc_sel) begin
            commit  <= 1'b1;
            state_q <= LOCKED;
            locked  <= 1'b1;
         end else if (acc_unlock) begin
            state_q <= EDIT;
            locked  <= 1'b0;
         end else if (acc_inc || acc_dec) begin
            ovf <= 1'b0;
         end else if (acc_left) begin
            cursor <= (cursor == CUR_W'(DIGITS - 1)) ? '0 : cursor + CUR_W'(1);
         end else if (acc_right) begin
            cursor <= (cursor == '0) ? CUR_W'(DIGITS - 1) : cursor - CUR_W'(1);
         end
      end
   end

   bin2bcd_seq #(
      .DIGITS    (DIGITS),
      .BIN_W     (BIN_W),
      .RESET_BCD (RESET_BCD32[4*DIGITS-1:0])
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (next_value),
      .bcd   (digits),
      .done  (conv_done)
   );

endmodule

// File: tb/tb_bcd_value_select.sv
// tb/tb_bcd_value_select.sv - directed self-checking bench for bcd_value_select
module tb_bcd_value_select;

   localparam logic [7:0] M_RST   = 8'h80;
   localparam logic [7:0] M_LOAD  = 8'h40;
   localparam logic [7:0] M_SEL   = 8'h20;
   localparam logic [7:0] M_UNL   = 8'h10;
   localparam logic [7:0] M_INC   = 8'h08;
   localparam logic [7:0] M_DEC   = 8'h04;
   localparam logic [7:0] M_LEFT  = 8'h02;
   localparam logic [7:0] M_RIGHT = 8'h01;

   logic        clk = 1'b0;
   logic        reset, inc, dec, left, right, sel, unlock, load;
   logic [13:0] load_bin;

   logic [13:0] value_w, value_s;
   logic [15:0] digits_w, digits_s;
   logic [1:0]  cursor_w, cursor_s;
   logic        locked_w, busy_w, commit_w, ovf_w;
   logic        locked_s, busy_s, commit_s, ovf_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bcd_value_select #(.DIGITS(4), .BIN_W(14), .MIN_VALUE(0), .MAX_VALUE(9999), .WRAP(1)) dut (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .left(left), .right(right),
      .sel(sel), .unlock(unlock), .load(load), .load_bin(load_bin),
      .value_bin(value_w), .digits(digits_w), .cursor(cursor_w), .locked(locked_w),
      .busy(busy_w), .commit(commit_w), .ovf(ovf_w)
   );

   bcd_value_select #(.DIGITS(4), .BIN_W(14), .MIN_VALUE(0), .MAX_VALUE(9999), .WRAP(0)) dut_s (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .left(left), .right(right),
      .sel(sel), .unlock(unlock), .load(load), .load_bin(load_bin),
      .value_bin(value_s), .digits(digits_s), .cursor(cursor_s), .locked(locked_s),
      .busy(busy_s), .commit(commit_s), .ovf(ovf_s)
   );

   task automatic drive(input logic [7:0] m, input logic [13:0] lb);
      {reset, load, sel, unlock, inc, dec, left, right} = m;
      load_bin = lb;
      @(negedge clk);
      {reset, load, sel, unlock, inc, dec, left, right} = '0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy_w) n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      drive(M_RST, 14'd0);
      tests++;
      if ({value_w, digits_w, cursor_w, locked_w, busy_w, commit_w, ovf_w} !== '0) begin
         fails++;
         $display("FAIL reset_wrap: got v=%0d d=%h c=%0d l=%b b=%b cm=%b o=%b expected all zero",
                  value_w, digits_w, cursor_w, locked_w, busy_w, commit_w, ovf_w);
      end
      tests++;
      if ({value_s, digits_s, cursor_s, locked_s, busy_s, commit_s, ovf_s} !== '0) begin
         fails++;
         $display("FAIL reset_sat: got v=%0d d=%h c=%0d l=%b b=%b cm=%b o=%b expected all zero",
                  value_s, digits_s, cursor_s, locked_s, busy_s, commit_s, ovf_s);
      end
   endtask

   task automatic test_inc_steps();
      int n;
      for (int r = 1; r <= 3; r++) begin
         drive(M_INC, 14'd0);
         tests++;
         if (value_w !== 14'(r) || busy_w !== 1'b1) begin
            fails++;
            $display("FAIL inc_value: got v=%0d busy=%b expected v=%0d busy=1", value_w, busy_w, r);
         end
         tests++;
         if (digits_w !== 16'(r - 1)) begin
            fails++;
            $display("FAIL inc_stale_digits: got %h expected %h", digits_w, 16'(r - 1));
         end
         count_busy(n);
         tests++;
         if (n !== 15) begin
            fails++;
            $display("FAIL inc_busy_len: got %0d expected 15", n);
         end
         tests++;
         if (digits_w !== 16'(r)) begin
            fails++;
            $display("FAIL inc_digits: got %h expected %h", digits_w, 16'(r));
         end
      end
   endtask

   task automatic test_dec_wrap();
      int n;
      drive(M_RST, 14'd0);
      drive(M_DEC, 14'd0);
      count_busy(n);
      tests++;
      if (value_w !== 14'd9999 || digits_w !== 16'h9999) begin
         fails++;
         $display("FAIL dec_wrap: got v=%0d d=%h expected v=9999 d=9999", value_w, digits_w);
      end
      tests++;
      if (value_s !== 14'd0 || digits_s !== 16'h0000) begin
         fails++;
         $display("FAIL dec_sat: got v=%0d d=%h expected v=0 d=0000", value_s, digits_s);
      end
   endtask

   task automatic test_cursor_wrap();
      int n;
      drive(M_LOAD, 14'd9500);
      drive(M_UNL, 14'd0);
      repeat (3) drive(M_LEFT, 14'd0);
      tests++;
      if (cursor_w !== 2'd3 || cursor_s !== 2'd3) begin
         fails++;
         $display("FAIL cursor_left3: got %0d/%0d expected 3/3", cursor_w, cursor_s);
      end
      wait_cyc(20);
      drive(M_INC, 14'd0);
      tests++;
      if (value_w !== 14'd500 || value_s !== 14'd9999) begin
         fails++;
         $display("FAIL inc_k_wrap_sat: got %0d/%0d expected 500/9999", value_w, value_s);
      end
      count_busy(n);
      tests++;
      if (digits_w !== 16'h0500 || digits_s !== 16'h9999) begin
         fails++;
         $display("FAIL inc_k_digits: got %h/%h expected 0500/9999", digits_w, digits_s);
      end
      drive(M_LEFT, 14'd0);
      tests++;
      if (cursor_w !== 2'd0) begin
         fails++;
         $display("FAIL cursor_left_wrap: got %0d expected 0", cursor_w);
      end
   endtask

   task automatic test_sel_lock();
      drive(M_SEL, 14'd0);
      tests++;
      if (commit_w !== 1'b1 || locked_w !== 1'b1) begin
         fails++;
         $display("FAIL sel_commit: got commit=%b locked=%b expected 1/1", commit_w, locked_w);
      end
      wait_cyc(1);
      tests++;
      if (commit_w !== 1'b0 || locked_w !== 1'b1) begin
         fails++;
         $display("FAIL commit_pulse: got commit=%b locked=%b expected 0/1", commit_w, locked_w);
      end
      drive(M_SEL, 14'd0);
      tests++;
      if (commit_w !== 1'b0) begin
         fails++;
         $display("FAIL sel_in_locked: got commit=%b expected 0", commit_w);
      end
      drive(M_INC, 14'd0);
      tests++;
      if (value_w !== 14'd500 || busy_w !== 1'b0) begin
         fails++;
         $display("FAIL inc_locked: got v=%0d busy=%b expected v=500 busy=0", value_w, busy_w);
      end
      drive(M_UNL, 14'd0);
      tests++;
      if (locked_w !== 1'b0) begin
         fails++;
         $display("FAIL unlock: got locked=%b expected 0", locked_w);
      end
      drive(M_INC, 14'd0);
      tests++;
      if (value_w !== 14'd501 || value_s !== 14'd9999) begin
         fails++;
         $display("FAIL inc_after_unlock: got %0d/%0d expected 501/9999", value_w, value_s);
      end
      wait_cyc(20);
      tests++;
      if (digits_w !== 16'h0501) begin
         fails++;
         $display("FAIL unlock_digits: got %h expected 0501", digits_w);
      end
   endtask

   task automatic test_load();
      int  n;
      logic saw_stale;
      drive(M_LOAD, 14'd12345);
      tests++;
      if (value_w !== 14'd9999 || ovf_w !== 1'b1 || locked_w !== 1'b1) begin
         fails++;
         $display("FAIL load_clamp: got v=%0d ovf=%b locked=%b expected 9999/1/1", value_w, ovf_w, locked_w);
      end
      count_busy(n);
      tests++;
      if (n !== 15 || digits_w !== 16'h9999) begin
         fails++;
         $display("FAIL load_clamp_digits: got busy=%0d d=%h expected 15/9999", n, digits_w);
      end
      drive(M_LOAD, 14'd42);
      tests++;
      if (value_w !== 14'd42 || ovf_w !== 1'b0) begin
         fails++;
         $display("FAIL load_42: got v=%0d ovf=%b expected 42/0", value_w, ovf_w);
      end
      wait_cyc(20);
      tests++;
      if (digits_w !== 16'h0042) begin
         fails++;
         $display("FAIL load_42_digits: got %h expected 0042", digits_w);
      end
      drive(M_LOAD, 14'd1234);
      wait_cyc(4);
      drive(M_LOAD, 14'd777);
      saw_stale = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (digits_w === 16'h1234) saw_stale = 1'b1;
         if (busy_w) n++;
         @(negedge clk);
      end
      tests++;
      if (saw_stale !== 1'b0 || n !== 15 || digits_w !== 16'h0777) begin
         fails++;
         $display("FAIL load_restart: got stale=%b busy=%0d d=%h expected 0/15/0777", saw_stale, n, digits_w);
      end
   endtask

   task automatic test_back_to_back();
      drive(M_UNL, 14'd0);
      drive(M_INC | M_DEC, 14'd0);
      tests++;
      if (value_w !== 14'd778 || value_s !== 14'd778) begin
         fails++;
         $display("FAIL inc_dec_same: got %0d/%0d expected 778/778", value_w, value_s);
      end
      wait_cyc(3);
      drive(M_INC, 14'd0);
      tests++;
      if (value_w !== 14'd778) begin
         fails++;
         $display("FAIL inc_while_busy: got %0d expected 778", value_w);
      end
      drive(M_RIGHT, 14'd0);
      tests++;
      if (cursor_w !== 2'd3) begin
         fails++;
         $display("FAIL right_wrap_busy: got %0d expected 3", cursor_w);
      end
      wait_cyc(20);
      tests++;
      if (digits_w !== 16'h0778) begin
         fails++;
         $display("FAIL b2b_digits: got %h expected 0778", digits_w);
      end
   endtask

   task automatic test_reset_mid();
      drive(M_INC, 14'd0);
      tests++;
      if (value_w !== 14'd1778) begin
         fails++;
         $display("FAIL inc_thousands: got %0d expected 1778", value_w);
      end
      wait_cyc(5);
      drive(M_RST, 14'd0);
      tests++;
      if (value_w !== 14'd0 || busy_w !== 1'b0 || digits_w !== 16'h0000 || cursor_w !== 2'd0) begin
         fails++;
         $display("FAIL reset_mid: got v=%0d b=%b d=%h c=%0d expected 0/0/0000/0",
                  value_w, busy_w, digits_w, cursor_w);
      end
      wait_cyc(20);
      tests++;
      if (digits_w !== 16'h0000 || busy_w !== 1'b0) begin
         fails++;
         $display("FAIL reset_abort: got d=%h b=%b expected 0000/0", digits_w, busy_w);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      {reset, load, sel, unlock, inc, dec, left, right} = '0;
      load_bin = '0;
      @(negedge clk);
      test_reset();
      test_inc_steps();
      test_dec_wrap();
      test_cursor_wrap();
      test_sel_lock();
      test_load();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bcd_value_select.md
Name: bcd_value_select

Overview:
Parametrised successor to the button-driven BCD X-selection logic. Holds one binary value, edited by debounced inc/dec pulses at a selectable decimal digit position (cursor). Supports wrap or saturate at configurable bounds, a commit/lock handshake, and a load path for displaying computed results. Its BCD digit outputs are derived from the binary value by a sequential double-dabble converter and feed SS_Driver directly.

Parameters:
DIGITS, 4, number of BCD digits presented (1..8)
BIN_W, 14, binary value width; 10^DIGITS-1 must fit in BIN_W bits
MIN_VALUE, 0, lower bound of the value range
MAX_VALUE, 9999, upper bound; MAX_VALUE-MIN_VALUE+1 >= 10^(DIGITS-1)
WRAP, 1, 1 = wrap modulo range on over/underflow, 0 = saturate at bounds

Ports:
clk  in  1  system clock (CLK100MHZ at top)
reset  in  1  synchronous, active-high reset
inc  in  1  single-cycle pulse: add 10^cursor
dec  in  1  single-cycle pulse: subtract 10^cursor
left  in  1  pulse: cursor+1 (wraps DIGITS-1 -> 0)
right  in  1  pulse: cursor-1 (wraps 0 -> DIGITS-1)
sel  in  1  pulse: commit value and lock
unlock  in  1  pulse: return from LOCKED to EDIT
load  in  1  pulse: replace value with load_bin
load_bin  in  BIN_W  value captured on load
value_bin  out  BIN_W  current binary value
digits  out  4*DIGITS  BCD digits; digit k at [4k+3:4k]
cursor  out  $clog2(DIGITS) (min 1)  active digit position
locked  out  1  high in LOCKED
busy  out  1  BCD conversion in progress; digits stale
commit  out  1  one-cycle pulse on accepted sel
ovf  out  1  last load was out of range and was clamped

Behaviour:
- Reset (synchronous, overrides everything; aborts any conversion): state EDIT, value_bin=MIN_VALUE, digits=BCD(MIN_VALUE) (elaboration constant), cursor=0, locked=0, busy=0, commit=0, ovf=0.
- States: EDIT, LOCKED. The converter runs independently; busy reflects it.
- Per-cycle priority: load > sel > unlock > inc > dec > left > right. At most one action is accepted per cycle; lower-priority pulses in the same cycle are dropped.
- load (any state, including while busy): value_bin <= clamp(load_bin, MIN, MAX); ovf <= (load_bin>MAX || load_bin<MIN); state -> LOCKED; conversion restarts (an in-progress conversion is aborted).
- sel: accepted in EDIT, even while busy; commit=1 for exactly one cycle; state -> LOCKED. sel in LOCKED is ignored.
- unlock: accepted in LOCKED -> EDIT; ignored in EDIT.
- inc/dec: accepted only in EDIT with busy=0; otherwise dropped. step = 10^cursor.
  - inc: s = value+step. If s>MAX: WRAP ? s-(MAX-MIN+1) : MAX.
  - dec: s = value-step, computed signed on BIN_W+1 bits. If s<MIN: WRAP ? s+(MAX-MIN+1) : MIN.
  - An accepted inc/dec clears ovf and starts a conversion.
- left/right: accepted only in EDIT; allowed while busy; affect only cursor.
- Conversion timing: an action accepted at edge E0 updates value_bin at E0 and sets busy=1 after E0. digits update at edge E0+BIN_W+1 and busy=0 after that edge, so busy is high for BIN_W+1 cycles. digits holds its old value until the update.
- locked = (state==LOCKED), registered.

Decomposition:
- Package bcd_pkg: POW10 constant table (10^0..10^7, 32-bit), function to_bcd_const(value, digits) for reset digits, state encoding (EDIT, LOCKED).
- Sub-module bin2bcd_seq: iterative shift-add-3 converter with ports clk, reset, start, bin[BIN_W], bcd[4*DIGITS], done. start aborts and restarts any run. done is a one-cycle pulse BIN_W+1 cycles after start.

Test Plan:
All scenarios use DIGITS=4, BIN_W=14, MIN=0, MAX=9999 unless noted.
1. Reset, then 3 inc pulses at cursor 0, each 20 cycles apart -> value_bin=3, digits=0x0003; busy high exactly 15 cycles after each inc.
2. From 0, dec: WRAP=1 -> 9999, digits 0x9999. WRAP=0 -> value stays 0.
3. left x3 (cursor=3) from value 9500, then inc: WRAP=1 -> 500 / 0x0500; WRAP=0 -> 9999. Fourth left -> cursor 0.
4. sel in EDIT -> commit high for 1 cycle, locked=1; subsequent inc ignored (value unchanged); unlock -> locked=0 and inc is accepted again.
5. load with load_bin=12345 -> value_bin=9999, ovf=1, locked=1, digits 0x9999 after 15 cycles. Then load 42 -> ovf=0, digits 0x0042. load issued mid-conversion -> only the last value appears on digits.
6. inc and dec in the same cycle -> only inc applied. inc during busy -> dropped. reset mid-conversion -> reset values on the next cycle, busy=0.
